// File: rtl/nor_flash_memory_if.sv
// rtl/nor_flash_memory_if.sv - host-side strobe/address/data bundle for the NOR flash model
interface nor_flash_memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;

  modport master (output we, re, address, data_in, input data_out, busy);
  modport slave  (input we, re, address, data_in, output data_out, busy);
endinterface

// File: rtl/nor_flash_memory.sv
// rtl/nor_flash_memory.sv - byte-wide NOR flash model with unlock-sequence sector/chip erase
module nor_flash_memory #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int SECTOR_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  nor_flash_memory_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, UNLOCK1, UNLOCK2, ERASE} state_t;

  // Array is nonvolatile: erased at time zero, never touched by rst.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: {DATA_WIDTH{1'b1}}};

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] base, base_next;
  logic [ADDR_WIDTH-1:0] last, last_next;
  logic                  prog;
  logic                  erase_we;
  logic [ADDR_WIDTH-1:0] erase_addr;
  logic                  unlock1_hit;
  logic                  unlock2_hit;

  assign unlock1_hit = (bus.address == ADDR_WIDTH'(8'hAA)) && (bus.data_in == DATA_WIDTH'(8'h55));
  assign unlock2_hit = (bus.address == ADDR_WIDTH'(8'h55)) && (bus.data_in == DATA_WIDTH'(8'hAA));
  assign erase_we    = (state == ERASE);
  assign erase_addr  = base | cnt;
  assign bus.busy    = (state == ERASE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    base_next  = base;
    last_next  = last;
    prog       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.we) begin
          if (unlock1_hit) state_next = UNLOCK1;
          else             prog       = 1'b1;
        end
      end
      UNLOCK1: begin
        if (bus.we) begin
          if (unlock2_hit) begin
            state_next = UNLOCK2;
          end else begin
            state_next = IDLE;
            prog       = 1'b1;
          end
        end
      end
      UNLOCK2: begin
        // Whatever is written here is a command byte and never reaches the array.
        if (bus.we) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (bus.data_in == DATA_WIDTH'(8'h30)) begin
            state_next = ERASE;
            base_next  = {bus.address[ADDR_WIDTH-1:SECTOR_BITS], {SECTOR_BITS{1'b0}}};
            last_next  = {{(ADDR_WIDTH-SECTOR_BITS){1'b0}}, {SECTOR_BITS{1'b1}}};
          end else if (bus.data_in == DATA_WIDTH'(8'h10)) begin
            state_next = ERASE;
            base_next  = '0;
            last_next  = '1;
          end
        end
      end
      ERASE: begin
        cnt_next = cnt + 1'b1;
        if (cnt == last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      base         <= '0;
      last         <= '0;
      bus.data_out <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      base  <= base_next;
      last  <= last_next;
      if (bus.re && !bus.we && state != ERASE)
        bus.data_out <= mem[bus.address];
    end
  end

  // Programming ANDs into the cell, so bits only ever move 1 -> 0.
  always_ff @(posedge clk) begin
    if (erase_we)
      mem[erase_addr] <= {DATA_WIDTH{1'b1}};
    else if (prog)
      mem[bus.address] <= mem[bus.address] & bus.data_in;
  end
endmodule

// File: tb/tb_nor_flash_memory.sv
// tb/tb_nor_flash_memory.sv - randomized scoreboard bench for nor_flash_memory
module tb_nor_flash_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nor_flash_memory_if bus ();
  nor_flash_memory dut (.clk(clk), .rst(rst), .bus(bus));

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] last_out = 8'h00;
  int         stage = 0;
  logic [7:0] want_q [$];
  string      name_q [$];
  logic       rd_issue = 1'b0;
  logic       busy_s;
  bit         pend_start;
  int         pend_base, pend_len;

  task automatic check(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Reference: the host-visible command protocol applied to a plain byte array.
  task automatic model_write(logic [7:0] a, logic [7:0] d);
    pend_start = 0;
    if (stage == 0) begin
      if (a == 8'hAA && d == 8'h55) stage = 1;
      else ref_mem[a] = ref_mem[a] & d;
    end else if (stage == 1) begin
      if (a == 8'h55 && d == 8'hAA) stage = 2;
      else begin stage = 0; ref_mem[a] = ref_mem[a] & d; end
    end else begin
      stage = 0;
      if (d == 8'h30) begin pend_start = 1; pend_base = a & 8'hF0; pend_len = 16; end
      else if (d == 8'h10) begin pend_start = 1; pend_base = 0; pend_len = 256; end
    end
  endtask

  task automatic model_erase(int n);
    for (int i = 0; i < n; i++) ref_mem[pend_base + i] = 8'hFF;
  endtask

  task automatic drive(logic w, logic r, logic [7:0] a, logic [7:0] d);
    @(negedge clk);
    busy_s      = bus.busy;
    bus.we      = w;
    bus.re      = r;
    bus.address = a;
    bus.data_in = d;
    rd_issue    = r;
  endtask

  task automatic push_read(logic [7:0] want, string nm);
    last_out = want;
    want_q.push_back(want);
    name_q.push_back(nm);
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    drive(1'b1, 1'b0, a, d);
    if (!busy_s) model_write(a, d);
  endtask

  task automatic rd(logic [7:0] a, string nm);
    drive(1'b0, 1'b1, a, 8'h00);
    push_read(busy_s ? last_out : ref_mem[a], nm);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Counts busy cycles while firing random ignored reads/writes at the DUT.
  task automatic wait_erase(int len, string nm);
    int cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        bus.we = 0; bus.re = 0; rd_issue = 0;
        break;
      end
      cnt++;
      bus.we      = 1'($urandom);
      bus.re      = 1'($urandom);
      bus.address = 8'($urandom);
      bus.data_in = 8'($urandom);
      rd_issue    = bus.re;
      if (bus.re) push_read(last_out, "read_during_busy");
    end
    check(nm, cnt, len);
    model_erase(len);
  endtask

  initial begin : monitor
    logic [7:0] want;
    string nm;
    forever begin
      @(posedge clk);
      if (rd_issue) begin
        @(negedge clk);
        if (want_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL scoreboard_underflow: got read with no expectation");
        end else begin
          want = want_q.pop_front();
          nm   = name_q.pop_front();
          check(nm, bus.data_out, want);
        end
      end
    end
  end

  initial begin
    logic [7:0] pa [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    logic [7:0] pd [7] = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
    bus.we = 0; bus.re = 0; bus.address = 0; bus.data_in = 0;
    repeat (2) @(negedge clk);
    check("reset_data_out", bus.data_out, 8'h00);
    check("reset_busy", bus.busy, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wr(pa[i], pd[i]);
      rd(pa[i], "prog_readback");
    end

    wr(8'h10, 8'h0F);
    wr(8'h10, 8'hF0);
    rd(8'h10, "bit_clear");
    rd(8'h99, "unwritten_ff");

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(8'h60, 8'hA0));
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b1, 1'b1, a, d);
        model_write(a, d);
        push_read(last_out, "we_re_same_edge");
      end else begin
        wr(a, d);
      end
      rd(8'($urandom_range(8'h60, 8'hA0)), "random_readback");
    end

    wr(8'h21, 8'h00);
    wr(8'h31, 8'h00);
    wr(8'hAA, 8'h55);
    wr(8'h55, 8'hAA);
    wr(8'h25, 8'h30);
    wait_erase(16, "sector_busy_len");
    rd(8'h21, "sector_erased");
    rd(8'h31, "outside_sector");
    rd(8'h2F, "sector_last_word");

    wr(8'hAA, 8'h55);
    wr(8'h40, 8'h3C);
    rd(8'h40, "broken_unlock_prog");
    wr(8'hAA, 8'h55);
    wr(8'h55, 8'hAA);
    wr(8'h12, 8'h77);
    idle();
    check("abort_no_busy", bus.busy, 1'b0);
    rd(8'h12, "abort_no_prog");
    rd(8'h01, "abort_no_change");
    wr(8'h13, 8'h5A);
    rd(8'h13, "idle_after_abort");

    wr(8'hAA, 8'h55);
    wr(8'h55, 8'hAA);
    wr(8'h00, 8'h10);
    wait_erase(256, "chip_busy_len");
    rd(8'h01, "chip_erased_01");
    rd(8'h10, "chip_erased_10");
    rd(8'h31, "chip_erased_31");
    rd(8'h40, "chip_erased_40");
    rd(8'($urandom), "chip_erased_rand");

    for (int i = 0; i < 16; i++) wr(8'(8'h50 + i), 8'h00);
    wr(8'h70, 8'h11);
    rd(8'h70, "pre_reset_read");
    wr(8'hAA, 8'h55);
    wr(8'h55, 8'hAA);
    wr(8'h53, 8'h30);
    repeat (5) idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_data_out", bus.data_out, 8'h00);
    last_out = 8'h00;
    model_erase(5);
    stage = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rd(8'(8'h50 + i), "aborted_sector");
    rd(8'h70, "survives_reset");

    repeat (3) idle();
    check("scoreboard_drained", want_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nor_flash_memory.md
Name: nor_flash_memory

Overview:
- Byte-wide, single-clock behavioural NOR flash model with 256 locations.
- Plain write cycles program bytes. Programming can only clear bits (1->0).
- A three-cycle unlock/command sequence triggers sector or chip erase, which restores bits to 1.
- Used as a nonvolatile storage model behind a simple synchronous we/re host interface.

Parameters:
- ADDR_WIDTH, 8, address bits. Depth is 2^ADDR_WIDTH. Must be >= 8.
- DATA_WIDTH, 8, data word width.
- SECTOR_BITS, 4, log2 of sector size in words. Sector index is address[ADDR_WIDTH-1:SECTOR_BITS].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write-cycle strobe, sampled at rising edge.
- re  input  1  read strobe, sampled at rising edge.
- address  input  ADDR_WIDTH  word address for read, program and command cycles.
- data_in  input  DATA_WIDTH  program data or command code.
- data_out  output  DATA_WIDTH  registered read data.
- busy  output  1  high while an erase is in progress.

Behaviour:
- Array initial state:
  - All locations are 0xFF (erased) at time zero.
  - rst never modifies array contents (nonvolatile).
- Reset (async, rst=1):
  - data_out=0, busy=0, command state=IDLE, erase counter=0.
  - An erase in progress is aborted; already-erased words stay 0xFF, the rest are unchanged.
- Read:
  - On a rising edge with re=1, we=0, busy=0: data_out <= mem[address]. One-cycle latency, visible after that edge.
  - With re=0, data_out holds its last value.
  - Reads while busy=1 are ignored; data_out holds.
- Program (plain write):
  - On a rising edge with we=1, busy=0, in a cycle not consumed as a command cycle: mem[address] <= mem[address] & data_in.
  - A read issued the very next cycle returns the new value.
  - Programming an already-programmed byte cannot set bits. Example: 0x0F programmed with 0xF0 reads 0x00.
- we=1 and re=1 on the same edge: the write is processed, the read is ignored, data_out holds.
- Command state machine (advances only on write edges with busy=0):
  - IDLE:
    - Write of data 0x55 to address 0xAA -> UNLOCK1. No program.
    - Any other write is a normal program; stay in IDLE.
  - UNLOCK1:
    - Write of data 0xAA to address 0x55 -> UNLOCK2. No program.
    - Any other write -> IDLE and is processed as a normal program.
  - UNLOCK2: the next write is always consumed as a command, never programmed.
    - data 0x30: sector erase of the sector containing address -> ERASE.
    - data 0x10: chip erase -> ERASE.
    - Any other data: abort -> IDLE, no array change.
  - ERASE:
    - busy=1 from the edge after the command edge.
    - One word is set to 0xFF per clock, lowest address first.
    - Duration: 2^SECTOR_BITS cycles for sector erase, 2^ADDR_WIDTH cycles for chip erase.
    - busy drops on the edge that writes the last word; state returns to IDLE.
    - we and re are ignored throughout ERASE.
  - Read cycles (re only) do not affect command state.
- Address compare for command cycles uses address[7:0], with upper bits zero.

Test Plan:
- Program/read-back: program 0x01<-0xAB, 0x02<-0xCD, 0x03<-0xEF, 0x04<-0x12, 0x05<-0x34, 0x06<-0x56, 0x07<-0x78, each followed by a read next cycle -> data_out equals the written byte one edge after the re edge.
- Bit-clear rule: program 0x10<-0x0F, then 0x10<-0xF0, read -> 0x00. An unwritten address reads 0xFF.
- Sector erase:
  - Program 0x21<-0x00 and 0x31<-0x00.
  - Write (0xAA,0x55), (0x55,0xAA), (0x25,0x30) -> busy high for exactly 16 cycles.
  - Then 0x21 reads 0xFF and 0x31 still reads 0x00.
  - Writes and reads during busy have no effect.
- Chip erase: unlock plus data 0x10 -> busy for 256 cycles, then all previously programmed bytes read 0xFF.
- Broken sequence: (0xAA,0x55) followed by a write (0x40,0x3C) -> no erase, 0x40 reads 0x3C, command state returns to IDLE. Unlock followed by data 0x77 -> abort, no array change.
- Reset: assert rst mid-erase at cycle 5 -> busy=0 and data_out=0 immediately; first 5 words of the sector are 0xFF, the rest unchanged. Contents programmed before reset survive reset.
